// File: rtl/key_event_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_event_if : scancode-in / key-event-out bundle for key_event_gen
// Revision 1.0
// ---------------------------------------------------------------------------
interface key_event_if #(
    parameter int NKEYS = 4
);
    logic             code_valid;
    logic [7:0]       code;
    logic             rpt_en;
    logic [NKEYS-1:0] held;
    logic [NKEYS-1:0] press;
    logic             tick;

    modport master (output code_valid, code, rpt_en, input held, press, tick);
    modport slave  (input code_valid, code, rpt_en, output held, press, tick);
endinterface
`default_nettype wire

// File: rtl/key_event_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_event_gen : PS/2 scancodes -> per-key held levels and debounced,
//                 typematic press pulses sampled on a divided tick.
// Revision 1.0
// ---------------------------------------------------------------------------
module key_event_gen #(
    parameter int                 NKEYS         = 4,
    parameter logic [NKEYS*8-1:0] KEYCODES      = {8'h1B, 8'h1D, 8'h23, 8'h1C},
    parameter int                 TICK_DIV      = 187500,
    parameter int                 REPEAT_DELAY  = 8,
    parameter int                 REPEAT_PERIOD = 3
) (
    input  logic       clk,
    input  logic       clr,
    key_event_if.slave bus
);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam int TW      = $clog2(TICK_DIV);
    localparam logic [RW-1:0] RPT_DELAY_V  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PERIOD_V = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] RPT_ONE      = RW'(1);
    localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);

    logic [TW-1:0]    tick_cnt;
    logic             tick_i;
    logic             tick_r;
    logic             brk;
    logic             is_break;
    logic             is_ext;
    logic [NKEYS-1:0] held;
    logic [NKEYS-1:0] held_s;
    logic [NKEYS-1:0] press;
    logic [NKEYS-1:0] match;
    logic [RW-1:0]    rpt_cnt [NKEYS];

    assign tick_i   = (tick_cnt == TICK_LAST);
    assign is_break = (bus.code == 8'hF0);
    assign is_ext   = (bus.code == 8'hE0);

    always_comb begin
        match = '0;
        for (int i = 0; i < NKEYS; i++) begin
            match[i] = (bus.code == KEYCODES[8*i +: 8]);
        end
    end

    // The E0 prefix is simply swallowed: it leaves brk alone and the next byte decodes normally.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tick_cnt <= '0;
            tick_r   <= 1'b0;
            brk      <= 1'b0;
            held     <= '0;
        end else begin
            tick_cnt <= tick_i ? '0 : tick_cnt + 1'b1;
            tick_r   <= tick_i;
            if (bus.code_valid) begin
                if (is_break) begin
                    brk <= 1'b1;
                end else if (!is_ext) begin
                    for (int i = 0; i < NKEYS; i++) begin
                        if (match[i]) begin
                            held[i] <= ~brk;
                        end
                    end
                    brk <= 1'b0;
                end
            end
        end
    end

    // Sampling only on tick_i gives the debounce; rpt_cnt reloads at 1 so it never reaches 0.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            press  <= '0;
            held_s <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                rpt_cnt[i] <= RPT_DELAY_V;
            end
        end else begin
            press <= '0;
            if (tick_i) begin
                held_s <= held;
                for (int i = 0; i < NKEYS; i++) begin
                    if (held[i] && !held_s[i]) begin
                        press[i]   <= 1'b1;
                        rpt_cnt[i] <= RPT_DELAY_V;
                    end else if (held[i] && bus.rpt_en) begin
                        if (rpt_cnt[i] == RPT_ONE) begin
                            press[i]   <= 1'b1;
                            rpt_cnt[i] <= RPT_PERIOD_V;
                        end else begin
                            rpt_cnt[i] <= rpt_cnt[i] - 1'b1;
                        end
                    end else begin
                        rpt_cnt[i] <= RPT_DELAY_V;
                    end
                end
            end
        end
    end

    assign bus.held  = held;
    assign bus.press = press;
    assign bus.tick  = tick_r;
endmodule
`default_nettype wire

// File: doc/key_event_gen.md
# key_event_gen

Parametrised key-event generator that turns the scancode byte stream from the PS/2 receiver into per-key held levels and debounced, rate-limited press pulses for the game logic. It supports NKEYS configurable scancodes, make/break (0xF0) parsing, ignores the 0xE0 extended prefix, and generates typematic auto-repeat pulses. It sits between the PS/2 byte receiver and the game controller, and replaces the fixed four-direction pulse decoder.

## Interface
- NKEYS, 4: number of tracked keys, 1..16.
- KEYCODES, {8'h1B,8'h1D,8'h23,8'h1C}: NKEYS*8 bits; slice [8i+7:8i] is the make code of key i. The default gives key0=left(1C), key1=right(23), key2=up(1D), key3=down(1B).
- TICK_DIV, 187500: sample period in clk cycles, >=2.
- REPEAT_DELAY, 8: ticks from the initial press pulse to the first repeat pulse, >=1.
- REPEAT_PERIOD, 3: ticks between subsequent repeat pulses, >=1.
- clk  in  1  system clock.
- clr  in  1  reset, asynchronous, active-high.
- code_valid  in  1  one-cycle strobe; code is valid in this cycle.
- code  in  8  received scancode byte.
- rpt_en  in  1  auto-repeat enable, level.
- held  out  NKEYS  current make/break state per key.
- press  out  NKEYS  one-clk pulse per press or repeat event.
- tick  out  1  one-clk sample strobe, exported for downstream pacing.

## Operation
- Reset values: held=0, press=0, tick=0, tick_cnt=0, held_s=0, brk=0, every rpt_cnt=REPEAT_DELAY.
- Parser (applies on code_valid only; bytes without code_valid are ignored):
  - 0xF0: set brk.
  - 0xE0: set ext; brk is unchanged. ext only swallows the prefix; the following byte matches normally.
  - Any other byte: for every i with KEYCODES[i]==code, set held[i] <= ~brk. Then clear brk and ext.
  - Unmatched bytes clear brk and ext and change no held bit.
  - Duplicate KEYCODES entries update all matching keys.
  - A break for a key already released has no effect.
- Tick generator: tick_cnt counts 0..TICK_DIV-1 and wraps. The internal tick_i is high when tick_cnt==TICK_DIV-1. The tick output is tick_i registered.
- On tick_i, for each key i:
  - Rising (held & ~held_s): press[i]<=1; rpt_cnt<=REPEAT_DELAY.
  - Held (held & held_s) and rpt_en: if rpt_cnt==1, press[i]<=1 and rpt_cnt<=REPEAT_PERIOD; otherwise rpt_cnt decrements.
  - Held and ~rpt_en: no pulse; rpt_cnt<=REPEAT_DELAY.
  - Not held: rpt_cnt<=REPEAT_DELAY.
  - In all cases held_s<=held.
- On all non-tick cycles press=0, so every press pulse is exactly one clk wide.
- A press and release that both fall within one tick window are not seen. This is the intended debounce.
- rpt_cnt width is clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). The counter never underflows.

## Timing
- The held update is visible one clk after the code_valid cycle.
- press and tick assert one clk after the tick_i cycle, in the same cycle as each other.
- First tick after reset: tick_i in cycle TICK_DIV-1, tick/press in cycle TICK_DIV.
- code_valid in the same cycle as tick_i: sampling uses the pre-update held. The new value is seen at the next tick.
- Worst-case press latency after a make byte: TICK_DIV+1 clks.
- rpt_en deasserted mid-hold: no further repeats. Re-enabling restarts the full REPEAT_DELAY.
- clr mid-operation: all state returns to reset values immediately. A held key after clr needs a fresh make byte.

## Test plan
All scenarios use TICK_DIV=4, REPEAT_DELAY=2, REPEAT_PERIOD=1.
- Reset: assert clr mid-count with a key held -> held=0, press=0, tick=0 immediately; first tick at cycle 4 after release.
- Make/break: send 1C, wait 2 ticks, send F0,1C -> exactly one press[0] pulse, coincident with tick; held[0] high between the make and break bytes, then 0.
- Auto-repeat: send 23 with rpt_en=1 and hold for 6 ticks -> press[1] pulses at ticks n, n+2, n+3, n+4, n+5. With rpt_en=0 -> only tick n.
- Prefix handling: send E0,1D -> held[2]=1. Send E0,F0,1D -> held[2]=0. Send F0,55 then 1B -> held[3]=1 (brk consumed by 55).
- Glitch filtering: send 1B then F0,1B inside one tick window -> no press[3] pulse, held[3] ends at 0.
- Simultaneity: assert code_valid=1C in the tick_i cycle -> no press at this tick; press[0] at the following tick.
